// File: rtl/flop_check_pkg.sv
// Shared types and constants for the flipflop response checker.
package flop_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } chk_state_e;

  localparam int unsigned MAX_LATENCY = 8;
  // Fill counter only has to reach MAX_LATENCY-1.
  localparam int unsigned FILL_W = $clog2(MAX_LATENCY);

  // One expected-value stage at the default 8-bit width.
  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } exp_stage_t;

endpackage

// File: rtl/flop_check_delay.sv
// LATENCY-stage valid/data shift register that models the DUV register path.
// flush drops every valid bit in one cycle; data keeps shifting.
module flop_check_delay
  import flop_check_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0] vld;
  logic [WIDTH-1:0]   dat [LATENCY];

  // Shift valid/data one stage per clock; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
    end else begin
      dat[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) dat[i] <= dat[i-1];
      if (flush) begin
        vld <= '0;
      end else begin
        vld[0] <= in_valid;
        for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/flop_response_checker.sv
// Response checker for the flipflop DUV: models the expected qout through a
// LATENCY-deep delay line, compares every cycle, counts matches/mismatches.
// Optional build macro FLOP_CHECK_FIRST_ERR_EN adds first-mismatch capture
// outputs (first_exp, first_got, first_cycle).
module flop_response_checker
  import flop_check_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             check_en,
  input  logic [WIDTH-1:0] qin,
  input  logic [WIDTH-1:0] qout,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] match_count,
  output logic             halted,
  output logic [1:0]       state
`ifdef FLOP_CHECK_FIRST_ERR_EN
  ,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got,
  output logic [15:0]      first_cycle
`endif
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_HALT  = CNT_MAX - 1'b1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY - 1);

  chk_state_e        state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              dly_valid;
  logic [WIDTH-1:0]  exp_data;
  logic              exp_valid;
  logic              do_cmp;
  logic              mismatch;

  flop_check_delay #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .flush     (~check_en),
    .in_valid  (check_en),
    .in_data   (qin),
    .out_valid (dly_valid),
    .out_data  (exp_data)
  );

  assign exp_valid = dly_valid & check_en;
  // Case inequality so X/Z on qout is reported as a mismatch in simulation.
  assign mismatch  = (qout !== exp_data);

  // Next-state logic: fill the model pipeline, then compare until halted.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    do_cmp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (check_en) begin
          state_d = FILL;
          fill_d  = '0;
        end
      end
      FILL: begin
        if (!check_en)                state_d = IDLE;
        else if (fill_q == FILL_LAST) state_d = CHECK;
        else                          fill_d  = fill_q + FILL_W'(1);
      end
      CHECK: begin
        do_cmp = exp_valid;
        if (do_cmp && mismatch && (err_count == CNT_HALT)) state_d = HALT;
        else if (!check_en)                                state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State, error pulse and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      err         <= 1'b0;
      err_count   <= '0;
      match_count <= '0;
      halted      <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      err     <= do_cmp & mismatch;
      halted  <= (state_d == HALT);
      if (do_cmp && mismatch && (err_count != CNT_MAX))
        err_count <= err_count + 1'b1;
      if (do_cmp && !mismatch && (match_count != CNT_MAX))
        match_count <= match_count + 1'b1;
    end
  end

  assign state = state_q;

`ifdef FLOP_CHECK_FIRST_ERR_EN
  logic        first_seen;
  logic [15:0] cycle_q;

  // Free-running cycle stamp and one-shot capture of the first mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_seen  <= 1'b0;
      cycle_q     <= '0;
      first_exp   <= '0;
      first_got   <= '0;
      first_cycle <= '0;
    end else begin
      if (cycle_q != 16'hFFFF) cycle_q <= cycle_q + 16'd1;
      if (do_cmp && mismatch && !first_seen) begin
        first_seen  <= 1'b1;
        first_exp   <= exp_data;
        first_got   <= qout;
        first_cycle <= cycle_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_flop_response_checker.sv
// Directed bench for flop_response_checker: two instances (LATENCY=1/CNT_W=4
// and LATENCY=3/CNT_W=8) each fed by a behavioural flipflop DUV model.
// Covers FLOP_CHECK_FIRST_ERR_EN outputs when that macro is defined.
module tb_flop_response_checker;
  import flop_check_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset    = 1'b1;
  logic       check_en = 1'b0;
  logic [7:0] qin      = 8'h00;
  logic       fault_on = 1'b0;
  logic       corrupt  = 1'b0;

  // Behavioural DUVs: one register and a three-register chain.
  logic [7:0] q1 = 8'h00;
  logic [7:0] q3a = 8'h00, q3b = 8'h00, q3c = 8'h00;
  always @(posedge clk) begin
    q1  <= qin;
    q3a <= qin;
    q3b <= q3a;
    q3c <= q3b;
  end

  logic [7:0] qout1, qout3;
  assign qout1 = fault_on ? 8'hA5 : (corrupt ? ~q1 : q1);
  assign qout3 = q3c;

  logic       err1, halt1, err3, halt3;
  logic [3:0] ecnt1, mcnt1;
  logic [7:0] ecnt3, mcnt3;
  logic [1:0] st1, st3;
`ifdef FLOP_CHECK_FIRST_ERR_EN
  logic [7:0]  fexp1, fgot1, fexp3, fgot3;
  logic [15:0] fcyc1, fcyc3;
`endif

  flop_response_checker #(.WIDTH(8), .LATENCY(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .check_en(check_en), .qin(qin), .qout(qout1),
    .err(err1), .err_count(ecnt1), .match_count(mcnt1), .halted(halt1), .state(st1)
`ifdef FLOP_CHECK_FIRST_ERR_EN
    , .first_exp(fexp1), .first_got(fgot1), .first_cycle(fcyc1)
`endif
  );

  flop_response_checker #(.WIDTH(8), .LATENCY(3), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .check_en(check_en), .qin(qin), .qout(qout3),
    .err(err3), .err_count(ecnt3), .match_count(mcnt3), .halted(halt3), .state(st3)
`ifdef FLOP_CHECK_FIRST_ERR_EN
    , .first_exp(fexp3), .first_got(fgot3), .first_cycle(fcyc3)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    check_en = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // IDLE beat with a dummy qin, then qin=0..7, one drain beat, then drop enable.
  task automatic run_stream(input logic inject);
    check_en = 1'b1;
    qin      = 8'hFF;
    tick();
    check_eq("fill_state", 32'(st1), 32'(FILL));
    for (int i = 0; i < 8; i++) begin
      qin      = 8'(i);
      fault_on = inject && (i == 4);
      tick();
      if (i == 0) check_eq("check_state", 32'(st1), 32'(CHECK));
      if (inject && (i == 3 || i == 5)) check_eq("err_quiet", 32'(err1), 32'd0);
      if (inject && i == 4) check_eq("err_pulse", 32'(err1), 32'd1);
    end
    fault_on = 1'b0;
    qin      = 8'h55;
    tick();
    check_en = 1'b0;
    tick();
    check_eq("drain_idle", 32'(st1), 32'(IDLE));
  endtask

  logic err_seen;

  initial begin
    // Reset then idle.
    do_reset(2);
    err_seen = 1'b0;
    repeat (10) begin
      tick();
      if (err1 || err3) err_seen = 1'b1;
    end
    check_eq("idle_state1", 32'(st1), 32'(IDLE));
    check_eq("idle_state3", 32'(st3), 32'(IDLE));
    check_eq("idle_ecnt1", 32'(ecnt1), 32'd0);
    check_eq("idle_mcnt1", 32'(mcnt1), 32'd0);
    check_eq("idle_mcnt3", 32'(mcnt3), 32'd0);
    check_eq("idle_halt1", 32'(halt1), 32'd0);
    check_eq("idle_err", 32'(err_seen), 32'd0);

    // Clean stream.
    run_stream(1'b0);
    check_eq("clean_mcnt1", 32'(mcnt1), 32'd8);
    check_eq("clean_ecnt1", 32'(ecnt1), 32'd0);
    check_eq("clean_mcnt3", 32'(mcnt3), 32'd6);
    check_eq("clean_ecnt3", 32'(ecnt3), 32'd0);

    // Single injected fault where 8'h03 is expected.
    do_reset(1);
    run_stream(1'b1);
    check_eq("fault_ecnt1", 32'(ecnt1), 32'd1);
    check_eq("fault_mcnt1", 32'(mcnt1), 32'd7);
    check_eq("fault_ecnt3", 32'(ecnt3), 32'd0);
`ifdef FLOP_CHECK_FIRST_ERR_EN
    check_eq("first_exp", 32'(fexp1), 32'h03);
    check_eq("first_got", 32'(fgot1), 32'hA5);
    check_eq("first_cycle", 32'(fcyc1), 32'd5);
    check_eq("first_exp3_clear", 32'(fexp3), 32'h00);
`endif

    // Persistent mismatch saturates the 4-bit error counter.
    do_reset(1);
    corrupt  = 1'b1;
    check_en = 1'b1;
    repeat (25) begin
      qin = qin + 8'd3;
      tick();
    end
    check_eq("sat_ecnt", 32'(ecnt1), 32'd15);
    check_eq("sat_halted", 32'(halt1), 32'd1);
    check_eq("sat_state", 32'(st1), 32'(HALT));
    err_seen = 1'b0;
    repeat (5) begin
      qin = qin + 8'd3;
      tick();
      if (err1) err_seen = 1'b1;
    end
    check_eq("halt_no_err", 32'(err_seen), 32'd0);
    check_eq("halt_ecnt", 32'(ecnt1), 32'd15);
    corrupt = 1'b0;
    do_reset(1);
    check_eq("halt_rst_ecnt", 32'(ecnt1), 32'd0);
    check_eq("halt_rst_halted", 32'(halt1), 32'd0);
    check_eq("halt_rst_state", 32'(st1), 32'(IDLE));

    // check_en toggle on the LATENCY=3 instance.
    check_en = 1'b1;
    qin = qin + 8'd1; tick();
    check_eq("tog_fill_a", 32'(st3), 32'(FILL));
    qin = qin + 8'd1; tick();
    qin = qin + 8'd1; tick();
    check_eq("tog_fill_b", 32'(st3), 32'(FILL));
    qin = qin + 8'd1; tick();
    check_eq("tog_check", 32'(st3), 32'(CHECK));
    repeat (5) begin
      qin = qin + 8'd1;
      tick();
    end
    check_eq("tog_mcnt_a", 32'(mcnt3), 32'd5);
    check_en = 1'b0;
    qin = qin + 8'd1; tick();
    check_eq("tog_idle", 32'(st3), 32'(IDLE));
    check_en = 1'b1;
    qin = qin + 8'd1; tick();
    qin = qin + 8'd1; tick();
    qin = qin + 8'd1; tick();
    check_eq("tog_refill", 32'(st3), 32'(FILL));
    check_eq("tog_mcnt_hold", 32'(mcnt3), 32'd5);
    qin = qin + 8'd1; tick();
    check_eq("tog_recheck", 32'(st3), 32'(CHECK));
    check_eq("tog_mcnt_b", 32'(mcnt3), 32'd5);
    repeat (4) begin
      qin = qin + 8'd1;
      tick();
    end
    check_eq("tog_mcnt_c", 32'(mcnt3), 32'd9);
    check_eq("tog_ecnt", 32'(ecnt3), 32'd0);

    // Mid-run reset with two errors logged.
    do_reset(1);
    check_en = 1'b1;
    tick();
    tick();
    corrupt = 1'b1;
    tick();
    tick();
    corrupt = 1'b0;
    tick();
    check_eq("pre_rst_ecnt", 32'(ecnt1), 32'd2);
    check_eq("pre_rst_mcnt", 32'(mcnt1), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_ecnt", 32'(ecnt1), 32'd0);
    check_eq("mid_rst_mcnt", 32'(mcnt1), 32'd0);
    check_eq("mid_rst_state", 32'(st1), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
